// File: rtl/pulse_gen_multi.sv
// Purpose : N independent programmable pulse channels (one-shot or periodic) with busy/sticky done.
// Latency : start sampled at edge k -> pulse from edge k+1; one-shot done/busy-low at edge k+P.
// Backpressure: none; enable low freezes a channel's counter and forces its pulse low.
//
// Ports:
//   clk, reset            - clock; synchronous active-high reset
//   start/enable/mode     - per-channel arm/restart, count enable, 0=one-shot 1=periodic
//   period/width          - per-channel CNT_W fields packed at [i*CNT_W +: CNT_W]
//   pulse/busy/done       - per-channel registered outputs (done is sticky)
module pulse_gen_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*CNT_W-1:0] period,
  input  logic [CHANNELS*CNT_W-1:0] width,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] w_q;
    logic             m_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] per_in;
    logic [CNT_W-1:0] p_d;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign per_in = period[i*CNT_W +: CNT_W];
    // A zero period would make P-1 wrap; treat it as a one-cycle period.
    assign p_d    = (per_in == '0) ? ONE : per_in;
    assign last   = (cnt_q == (p_q - ONE));
    // Counter wraps to 0 at end of period in both modes, so it never exceeds P-1.
    assign cnt_d  = last ? '0 : (cnt_q + ONE);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        p_q     <= '0;
        w_q     <= '0;
        m_q     <= 1'b0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (start[i]) begin
        // Restart from any state; pulse is forced low on the start edge.
        state_q <= RUN;
        cnt_q   <= '0;
        p_q     <= p_d;
        w_q     <= width[i*CNT_W +: CNT_W];
        m_q     <= mode[i];
        pulse_q <= 1'b0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          RUN: begin
            if (enable[i]) begin
              pulse_q <= (cnt_q < w_q);
              cnt_q   <= cnt_d;
              if (last && !m_q) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              pulse_q <= 1'b0;
            end
          end
          default: begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign pulse[i] = pulse_q;
    assign busy[i]  = busy_q;
    assign done[i]  = done_q;
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Purpose : self-checking bench for pulse_gen_multi (CHANNELS=2, CNT_W=32).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pulse_gen_multi;
  localparam int CH = 2;
  localparam int CW = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [CH-1:0]      start, enable, mode;
  logic [CH*CW-1:0]   period, width;
  logic [CH-1:0]      pulse, busy, done;

  always #5 clk = ~clk;

  pulse_gen_multi #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .mode(mode),
    .period(period), .width(width), .pulse(pulse), .busy(busy), .done(done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: a channel remembers how many enabled edges it has
  // seen since its last start; pulse/done follow from that count by arithmetic.
  bit            m_run  [CH];
  longint        m_n    [CH];
  longint        m_p    [CH];
  longint        m_w    [CH];
  bit            m_mode [CH];
  logic [CH-1:0] m_pulse, m_busy, m_done;

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < CH; i++) begin
      longint per, wid;
      per = longint'(period[i*CW +: CW]);
      wid = longint'(width[i*CW +: CW]);
      if (reset) begin
        m_run[i] = 0; m_n[i] = 0; m_p[i] = 0; m_w[i] = 0; m_mode[i] = 0;
        m_pulse[i] = 0; m_busy[i] = 0; m_done[i] = 0;
      end else if (start[i]) begin
        m_run[i] = 1; m_n[i] = 0; m_p[i] = (per == 0) ? 1 : per; m_w[i] = wid;
        m_mode[i] = mode[i]; m_pulse[i] = 0; m_busy[i] = 1; m_done[i] = 0;
      end else if (m_run[i] && enable[i]) begin
        m_pulse[i] = ((m_n[i] % m_p[i]) < m_w[i]);
        m_n[i]++;
        if (!m_mode[i] && m_n[i] == m_p[i]) begin
          m_run[i] = 0; m_busy[i] = 0; m_done[i] = 1;
        end
      end else begin
        m_pulse[i] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model_pulse", pulse, m_pulse);
    check("model_busy",  busy,  m_busy);
    check("model_done",  done,  m_done);
  endtask

  task automatic set_ch(input int i, input int per, input int wid, input bit md);
    period[i*CW +: CW] = CW'(per);
    width[i*CW +: CW]  = CW'(wid);
    mode[i]            = md;
  endtask

  typedef struct {
    bit            rst;
    logic [CH-1:0] st, en, md;
    int            p0, w0, p1, w1;
    logic [CH-1:0] e_pulse, e_busy, e_done;
  } vec_t;

  function automatic vec_t mk(bit rst, logic [1:0] st, logic [1:0] en, logic [1:0] md,
                              int p0, int w0, int p1, int w1,
                              logic [1:0] ep, logic [1:0] eb, logic [1:0] ed);
    vec_t v;
    v.rst = rst; v.st = st; v.en = en; v.md = md;
    v.p0 = p0; v.w0 = w0; v.p1 = p1; v.w1 = w1;
    v.e_pulse = ep; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    reset = 1'b1; start = '0; enable = '0; mode = '0; period = '0; width = '0;
    for (int i = 0; i < CH; i++) begin
      m_run[i] = 0; m_n[i] = 0; m_p[i] = 0; m_w[i] = 0; m_mode[i] = 0;
    end
    m_pulse = '0; m_busy = '0; m_done = '0;

    // ---------------- table-driven vectors ----------------
    // ch1 periodic P=3 W=1 with an enable gap; ch0 one-shot P=2 W=2; reset+start.
    tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tbl[1]  = mk(0, 2'b10, 2'b11, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[2]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b10, 2'b10, 2'b00);
    tbl[3]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[4]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[5]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b10, 2'b10, 2'b00);
    tbl[6]  = mk(0, 2'b00, 2'b01, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[7]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[8]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b00, 2'b10, 2'b00);
    tbl[9]  = mk(0, 2'b00, 2'b11, 2'b10, 0, 0, 3, 1, 2'b10, 2'b10, 2'b00);
    tbl[10] = mk(0, 2'b01, 2'b11, 2'b10, 2, 2, 3, 1, 2'b00, 2'b11, 2'b00);
    tbl[11] = mk(0, 2'b00, 2'b11, 2'b10, 2, 2, 3, 1, 2'b01, 2'b11, 2'b00);
    tbl[12] = mk(0, 2'b00, 2'b11, 2'b10, 2, 2, 3, 1, 2'b11, 2'b10, 2'b01);
    tbl[13] = mk(0, 2'b00, 2'b11, 2'b10, 2, 2, 3, 1, 2'b00, 2'b10, 2'b01);
    tbl[14] = mk(1, 2'b11, 2'b11, 2'b10, 2, 2, 3, 1, 2'b00, 2'b00, 2'b00);

    for (int r = 0; r < 15; r++) begin
      reset = tbl[r].rst; start = tbl[r].st; enable = tbl[r].en;
      set_ch(0, tbl[r].p0, tbl[r].w0, tbl[r].md[0]);
      set_ch(1, tbl[r].p1, tbl[r].w1, tbl[r].md[1]);
      tick();
      check($sformatf("tbl%0d_pulse", r), pulse, tbl[r].e_pulse);
      check($sformatf("tbl%0d_busy",  r), busy,  tbl[r].e_busy);
      check($sformatf("tbl%0d_done",  r), done,  tbl[r].e_done);
    end
    reset = 1'b0; start = '0;

    // ---------------- one-shot 5/1 and 20/1 ----------------
    set_ch(0, 5, 1, 0); set_ch(1, 20, 1, 0); enable = 2'b11; start = 2'b11;
    tick(); start = '0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      check("os_pulse", pulse, {1'(t == 1), 1'(t == 1)});
      check("os_busy",  busy,  {1'(t < 20), 1'(t < 5)});
      check("os_done",  done,  {1'(t >= 20), 1'(t >= 5)});
    end

    // ---------------- periodic 4/2 ----------------
    set_ch(0, 4, 2, 1); start = 2'b01;
    tick(); start = '0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      check("per_pulse0", pulse[0], 1'(((t - 1) % 4) < 2));
      check("per_busy0",  busy[0],  1'b1);
      check("per_done0",  done[0],  1'b0);
    end

    // ---------------- enable gap, one-shot 6/3 ----------------
    set_ch(0, 6, 3, 0); start = 2'b01;
    tick(); start = '0;
    for (int t = 1; t <= 10; t++) begin
      enable[0] = !(t >= 3 && t <= 5);
      tick();
      check("gap_pulse0", pulse[0], 1'(t == 1 || t == 2 || t == 6));
      check("gap_busy0",  busy[0],  1'(t < 9));
      check("gap_done0",  done[0],  1'(t >= 9));
    end
    enable = 2'b11;

    // ---------------- restart mid-run ----------------
    set_ch(0, 8, 4, 1); start = 2'b01;
    tick(); start = '0;
    for (int t = 1; t <= 5; t++) tick();
    set_ch(0, 3, 1, 1); start = 2'b01;
    tick(); start = '0;
    check("rs_edge_pulse0", pulse[0], 1'b0);
    check("rs_edge_busy0",  busy[0],  1'b1);
    set_ch(0, 8, 4, 1);  // inputs changed while running must be ignored
    for (int t = 1; t <= 9; t++) begin
      tick();
      check("rs_pulse0", pulse[0], 1'(((t - 1) % 3) == 0));
    end

    // ---------------- reset with start mid-run ----------------
    start = 2'b11; reset = 1'b1;
    tick();
    check("rst_pulse", pulse, 2'b00);
    check("rst_busy",  busy,  2'b00);
    check("rst_done",  done,  2'b00);
    start = '0; reset = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      check("idle_pulse", pulse, 2'b00);
      check("idle_busy",  busy,  2'b00);
    end

    // ---------------- period=0 width=0 one-shot ----------------
    set_ch(0, 0, 0, 0); start = 2'b01;
    tick(); start = '0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check("p0_pulse0", pulse[0], 1'b0);
      check("p0_done0",  done[0],  1'b1);
      check("p0_busy0",  busy[0],  1'b0);
    end

    // ---------------- width >= period periodic ----------------
    set_ch(0, 3, 5, 1); start = 2'b01;
    tick(); start = '0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("wide_pulse0", pulse[0], 1'b1);
    end

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(63) == 0);
      for (int i = 0; i < CH; i++) begin
        start[i]  = ($urandom_range(11) == 0);
        enable[i] = ($urandom_range(99) < 85);
        set_ch(i, int'($urandom_range(10)), int'($urandom_range(12)), 1'($urandom_range(1)));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
Name: pulse_gen_multi

Overview:
- Parametrised multi-channel pulse generator. Generalises the fixed short/long single-pulse counters into N independent channels.
- Each channel has a programmable period and pulse width, one-shot or periodic mode, run enable, restart and a sticky completion flag.
- Provides timing strobes and test stimulus to other blocks in the same clock domain.

Parameters:
- CHANNELS, 2, number of independent pulse channels (>=1).
- CNT_W, 32, width of each channel's period/width fields and internal counter.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-high reset.
- start  input  CHANNELS  bit i arms/restarts channel i. Latches period/width/mode for that channel.
- enable  input  CHANNELS  bit i lets channel i count; low freezes it.
- mode  input  CHANNELS  bit i: 0 = one-shot, 1 = periodic.
- period  input  CHANNELS*CNT_W  channel i at [i*CNT_W +: CNT_W]; period in clk cycles.
- width  input  CHANNELS*CNT_W  channel i at [i*CNT_W +: CNT_W]; high time in clk cycles.
- pulse  output  CHANNELS  registered pulse output per channel.
- busy  output  CHANNELS  registered; 1 while the channel is in RUN.
- done  output  CHANNELS  registered, sticky; 1 once a one-shot period has completed.

Behaviour:
- Channels are fully independent. The description below is per channel i; P, W and M are the latched period, width and mode.
- States: IDLE, RUN, DONE. Internal counter cnt is CNT_W bits.
- Reset (highest priority, synchronous): state=IDLE, cnt=0, pulse=0, busy=0, done=0, latched P/W/M=0.
- Start (priority over everything except reset, any state):
  - Latches P = (period==0 ? 1 : period), W = width, M = mode.
  - Sets cnt=0, state=RUN, busy=1, pulse=0, done=0.
  - Applies whether enable is high or low.
- RUN, enable=1, no start, per edge:
  - pulse <= (cnt < W).
  - If cnt == P-1: if M=1, cnt <= 0 and stay in RUN; if M=0, state <= DONE, busy <= 0, done <= 1, cnt <= 0.
  - Otherwise cnt <= cnt+1.
- RUN, enable=0: cnt holds, state holds, pulse <= 0. Counting resumes from the held cnt when enable returns.
- IDLE/DONE: pulse <= 0, cnt holds 0. done stays set in DONE until start or reset.
- Latency, start sampled at edge k:
  - pulse is high from edge k+1 for min(W,P) cycles per period.
  - One-shot: done and busy=0 appear at edge k+P, given continuous enable.
- Boundary conditions:
  - W=0: pulse never rises; timing and done are otherwise normal.
  - W>=P in periodic mode: pulse stays continuously high from k+1.
  - period=0 is treated as 1.
  - cnt never exceeds P-1, so it cannot wrap.
  - Start during RUN: restart. Forces one pulse-low cycle at the start edge, then a fresh sequence with the newly latched values.
  - Changes to period/width/mode inputs while in RUN are ignored until the next start.
  - Reset mid-operation aborts immediately to the reset values.
  - Start and reset in the same cycle: reset wins.
- Widths:
  - cnt compare is unsigned on CNT_W bits.
  - P-1 is computed on CNT_W bits; P>=1 is guaranteed by the period=0 rule.

Test Plan:
- CHANNELS=2. ch0: period=5, width=1, mode=0. ch1: period=20, width=1, mode=0. Both enabled, start both at edge k.
  -> ch0 pulse high only at k+1; done0 and busy0=0 at k+5.
  -> ch1 pulse high only at k+1; done1 at k+20.
  -> Both done flags stay 1 for 10 further cycles.
- ch0: period=4, width=2, mode=1, enabled, start at k.
  -> pulse pattern 1,1,0,0 repeating from k+1 for 12+ cycles; busy0 stays 1; done0 stays 0.
- ch0: period=6, width=3, mode=0. Deassert enable for 3 cycles after edge k+2.
  -> pulse=0 and cnt frozen while disabled.
  -> After re-enable, total high cycles = 3; done at k+6+3 = k+9.
- ch0 periodic, period=8, width=4. Pulse start again at cnt=5 with period=3, width=1.
  -> pulse=0 at the restart edge, then 1,0,0 repeating; old values not used.
- Mid-run: assert reset together with start.
  -> All outputs 0 next cycle; state IDLE; no pulse until a later start.
- period=0, width=0 one-shot.
  -> done at k+1, pulse never high.
- period=3, width=5 periodic.
  -> pulse constantly 1 from k+1.
